csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Parametrised machine-mode CSR execution unit.
- Replaces the fixed four-register CSR block that sits inside the decode stage.
- Executes the full Zicsr set (rw/rs/rc and their immediate forms), ecall, mret, and illegal-CSR traps through a valid/ready handshake.
- Returns the old CSR value and any PC redirect to the pipeline; exports live CSR state for the difftest hooks.

Parameters:
- XLEN, 32, data width of all CSRs and PCs.
- HART_ID, 0, value returned by mhartid (0xF14).
- MSTATUS_RESET, 32'h1800, reset value of mstatus (MPP=3).
- MCAUSE_RESET, 32'hb, reset value of mcause.
- MTVEC_RESET, 0, reset value of mtvec.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  001 rw, 010 rs, 011 rc, 101 rwi, 110 rsi, 111 rci, 000 system (ecall/mret selected by req_sys)
- req_sys  in  2  01 ecall, 10 mret; ignored when req_op!=000
- req_csr_addr  in  12  CSR address (instr[31:20])
- req_rs1_idx  in  5  rs1 index or zimm (instr[19:15])
- req_rs1_data  in  XLEN  rs1 value
- req_pc  in  XLEN  PC of the instruction
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  XLEN  old CSR value, to be written to rd
- resp_redirect  out  1  PC must be redirected
- resp_target  out  XLEN  redirect target
- resp_illegal  out  1  request raised an illegal-instruction trap
- mstatus_o, mtvec_o, mepc_o, mcause_o  out  XLEN each  live CSR values

Behaviour:
- Reset:
  - mstatus=MSTATUS_RESET, mtvec=MTVEC_RESET, mepc=0, mcause=MCAUSE_RESET, mscratch=0.
  - FSM=IDLE.
  - All resp_* outputs are 0 and req_ready=1.
- FSM states: IDLE and RESP.
  - IDLE: req_ready=1. When req_valid is high, the request is accepted.
  - On the acceptance edge: CSR side effects commit, the response registers load, and the FSM moves to RESP.
  - RESP: req_ready=0, resp_valid=1. Response fields are held stable until resp_ready. resp_valid & resp_ready moves the FSM to IDLE.
  - Latency is one cycle from acceptance to resp_valid. Throughput is one request per two cycles (no back-to-back acceptance).
- Source operand:
  - Immediate forms use {27'b0, req_rs1_idx}; register forms use req_rs1_data.
  - Write value by op: rw=src, rs=old|src, rc=old&~src.
- Write suppression: rs/rc/rsi/rci do not write when req_rs1_idx==0. rw/rwi always write.
- Implemented CSRs:
  - 0x300 mstatus: all bits writable.
  - 0x305 mtvec.
  - 0x340 mscratch.
  - 0x341 mepc: bits [1:0] always 0.
  - 0x342 mcause.
  - 0xF14 mhartid: read-only.
- Illegal-instruction trap is raised when either:
  - the address is unimplemented, or
  - a write is not suppressed and addr[11:10]==2'b11.
- Illegal-instruction trap actions:
  - No CSR write is performed.
  - mepc<=req_pc, mcause<=2, and the trap-entry mstatus update applies.
  - resp_illegal=1, resp_redirect=1, resp_target={mtvec[XLEN-1:2],2'b00}, resp_rdata=0.
- ecall:
  - mepc<=req_pc, mcause<=11.
  - mstatus: MPIE(bit7)<=MIE(bit3), MIE<=0, MPP(bits12:11)<=3.
  - Redirect to the aligned mtvec; resp_rdata=0.
- mret:
  - MIE<=MPIE, MPIE<=1, MPP<=3.
  - Redirect to mepc.
- req_op=000 with req_sys of 00 or 11: no side effects; all resp_* fields 0 except resp_valid.
- resp_rdata is the pre-write value.
- A request accepted after a write reads the new value; there is no bypass hazard because the FSM serialises requests.
- Synchronous reset in RESP drops the pending response; side effects already committed are overwritten by the reset values.
- mstatus_o..mcause_o always reflect the register contents, updated on the commit edge.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - Adds a 64-bit mcycle counter, readable and writable at 0xB00 (low word) and 0xB80 (high word).
  - The counter is reset to 0 and increments every cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - On a commit edge that writes either half, the written half takes the written value, the other half holds, and there is no increment that cycle.
  - A read returns the value before that cycle's increment.
- Undefined: 0xB00 and 0xB80 are unimplemented and raise the illegal-instruction trap.

Test Plan:
- Reset, then csrrs x0 on mstatus (rs1_idx=0, addr 0x300) -> resp_rdata=0x1800, no write, resp_redirect=0.
- csrrw mtvec with rs1_data=0x8000_0103, then csrrs read of mtvec -> second resp_rdata=0x8000_0103; a following ecall at pc 0x8000_0040 -> resp_target=0x8000_0100, mepc_o=0x8000_0040, mcause_o=11, mstatus_o=0x1800.
- Set mstatus=0x8 (MIE=1), ecall, then mret -> after ecall mstatus_o=0x1880; after mret mstatus_o=0x1888, resp_target=mepc.
- csrrc with rs1_data=0x8 on mstatus=0x1888 -> resp_rdata=0x1888, mstatus_o=0x1880; csrrwi on mscratch with zimm=0x1F -> mscratch reads back 0x1F.
- csrrw on mhartid, and csrrs on 0x7C0 with rs1_idx=3 -> resp_illegal=1, mcause_o=2, mepc_o=req_pc, CSRs otherwise unchanged.
- Hold resp_ready=0 for 5 cycles -> resp_valid and all resp fields stable, req_ready=0; with CSR_COUNTERS_EN, write mcycle=0xFFFF_FFFF, wait 2 cycles -> mcycleh=1 and mcycle=1.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR execution unit: Zicsr ops, ecall, mret and illegal-CSR traps
// behind a valid/ready handshake. Define CSR_COUNTERS_EN to add the 64-bit mcycle counter.
module csr_unit #(
    parameter int unsigned     XLEN          = 32,
    parameter logic [XLEN-1:0] HART_ID       = 32'h0000_0000,
    parameter logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800,
    parameter logic [XLEN-1:0] MCAUSE_RESET  = 32'h0000_000b,
    parameter logic [XLEN-1:0] MTVEC_RESET   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [1:0]      req_sys,
    input  logic [11:0]     req_csr_addr,
    input  logic [4:0]      req_rs1_idx,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [XLEN-1:0] req_pc,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_redirect,
    output logic [XLEN-1:0] resp_target,
    output logic            resp_illegal,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(32'd2);
    localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(32'd11);
    localparam logic [XLEN-1:0] ZERO          = XLEN'(32'd0);

    // Trap entry: stash MIE into MPIE, disable interrupts, previous mode = M.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] cur);
        logic [XLEN-1:0] nxt;
        nxt        = cur;
        nxt[7]     = cur[3];
        nxt[3]     = 1'b0;
        nxt[12:11] = 2'b11;
        return nxt;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] cur);
        logic [XLEN-1:0] nxt;
        nxt        = cur;
        nxt[3]     = cur[7];
        nxt[7]     = 1'b1;
        nxt[12:11] = 2'b11;
        return nxt;
    endfunction

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 2'b00};
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_redirect_q, resp_redirect_d;
    logic [XLEN-1:0] resp_target_q, resp_target_d;
    logic            resp_illegal_q, resp_illegal_d;
`ifdef CSR_COUNTERS_EN
    logic [63:0]     mcycle_q, mcycle_d;
`endif

    logic            is_csr_op_s;
    logic            is_ecall_s;
    logic            is_mret_s;
    logic            wr_en_s;
    logic            addr_ok_s;
    logic            illegal_s;
    logic [XLEN-1:0] src_s;
    logic [XLEN-1:0] old_val_s;
    logic [XLEN-1:0] wdata_s;

    // Request decode: operand select, old-value read, write value and legality.
    always_comb begin
        is_csr_op_s = (req_op[1:0] != 2'b00);
        is_ecall_s  = (req_op == 3'b000) && (req_sys == 2'b01);
        is_mret_s   = (req_op == 3'b000) && (req_sys == 2'b10);
        src_s       = req_op[2] ? XLEN'(req_rs1_idx) : req_rs1_data;
        wr_en_s     = is_csr_op_s && ((req_op[1:0] == 2'b01) || (req_rs1_idx != 5'd0));
        old_val_s   = ZERO;
        addr_ok_s   = 1'b1;
        case (req_csr_addr)
            ADDR_MSTATUS:  old_val_s = mstatus_q;
            ADDR_MTVEC:    old_val_s = mtvec_q;
            ADDR_MSCRATCH: old_val_s = mscratch_q;
            ADDR_MEPC:     old_val_s = mepc_q;
            ADDR_MCAUSE:   old_val_s = mcause_q;
            ADDR_MHARTID:  old_val_s = HART_ID;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:   old_val_s = XLEN'(mcycle_q[31:0]);
            ADDR_MCYCLEH:  old_val_s = XLEN'(mcycle_q[63:32]);
`endif
            default:       addr_ok_s = 1'b0;
        endcase
        case (req_op[1:0])
            2'b01:   wdata_s = src_s;
            2'b10:   wdata_s = old_val_s | src_s;
            2'b11:   wdata_s = old_val_s & ~src_s;
            default: wdata_s = old_val_s;
        endcase
        // Any write to the read-only quadrant traps, even to an implemented CSR.
        illegal_s = is_csr_op_s &&
                    (!addr_ok_s || (wr_en_s && (req_csr_addr[11:10] == 2'b11)));
    end

    // Handshake FSM, CSR commit and response register loading.
    always_comb begin
        state_d         = state_q;
        mstatus_d       = mstatus_q;
        mtvec_d         = mtvec_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mscratch_d      = mscratch_q;
        resp_rdata_d    = resp_rdata_q;
        resp_redirect_d = resp_redirect_q;
        resp_target_d   = resp_target_q;
        resp_illegal_d  = resp_illegal_q;
`ifdef CSR_COUNTERS_EN
        mcycle_d        = mcycle_q + 64'd1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d         = ST_RESP;
                    resp_rdata_d    = ZERO;
                    resp_redirect_d = 1'b0;
                    resp_target_d   = ZERO;
                    resp_illegal_d  = 1'b0;
                    if (illegal_s) begin
                        mepc_d          = align4(req_pc);
                        mcause_d        = CAUSE_ILLEGAL;
                        mstatus_d       = trap_mstatus(mstatus_q);
                        resp_illegal_d  = 1'b1;
                        resp_redirect_d = 1'b1;
                        resp_target_d   = align4(mtvec_q);
                    end else if (is_ecall_s) begin
                        mepc_d          = align4(req_pc);
                        mcause_d        = CAUSE_ECALL;
                        mstatus_d       = trap_mstatus(mstatus_q);
                        resp_redirect_d = 1'b1;
                        resp_target_d   = align4(mtvec_q);
                    end else if (is_mret_s) begin
                        mstatus_d       = mret_mstatus(mstatus_q);
                        resp_redirect_d = 1'b1;
                        resp_target_d   = mepc_q;
                    end else if (is_csr_op_s) begin
                        resp_rdata_d = old_val_s;
                        if (wr_en_s) begin
                            case (req_csr_addr)
                                ADDR_MSTATUS:  mstatus_d  = wdata_s;
                                ADDR_MTVEC:    mtvec_d    = wdata_s;
                                ADDR_MSCRATCH: mscratch_d = wdata_s;
                                ADDR_MEPC:     mepc_d     = align4(wdata_s);
                                ADDR_MCAUSE:   mcause_d   = wdata_s;
`ifdef CSR_COUNTERS_EN
                                ADDR_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wdata_s[31:0]};
                                ADDR_MCYCLEH:  mcycle_d   = {wdata_s[31:0], mcycle_q[31:0]};
`endif
                                default:       mscratch_d = mscratch_q;
                            endcase
                        end else begin
                            mscratch_d = mscratch_q;
                        end
                    end else begin
                        resp_rdata_d = ZERO;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d         = ST_IDLE;
                    resp_rdata_d    = ZERO;
                    resp_redirect_d = 1'b0;
                    resp_target_d   = ZERO;
                    resp_illegal_d  = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and CSR registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            mstatus_q       <= MSTATUS_RESET;
            mtvec_q         <= MTVEC_RESET;
            mepc_q          <= ZERO;
            mcause_q        <= MCAUSE_RESET;
            mscratch_q      <= ZERO;
            resp_rdata_q    <= ZERO;
            resp_redirect_q <= 1'b0;
            resp_target_q   <= ZERO;
            resp_illegal_q  <= 1'b0;
`ifdef CSR_COUNTERS_EN
            mcycle_q        <= 64'd0;
`endif
        end else begin
            state_q         <= state_d;
            mstatus_q       <= mstatus_d;
            mtvec_q         <= mtvec_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mscratch_q      <= mscratch_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_redirect_q <= resp_redirect_d;
            resp_target_q   <= resp_target_d;
            resp_illegal_q  <= resp_illegal_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q        <= mcycle_d;
`endif
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_rdata    = resp_rdata_q;
    assign resp_redirect = resp_redirect_q;
    assign resp_target   = resp_target_q;
    assign resp_illegal  = resp_illegal_q;
    assign mstatus_o     = mstatus_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mcause_o      = mcause_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit; counter checks follow CSR_COUNTERS_EN.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [1:0]  req_sys = 2'd0;
    logic [11:0] req_csr_addr = 12'd0;
    logic [4:0]  req_rs1_idx = 5'd0;
    logic [31:0] req_rs1_data = 32'd0;
    logic [31:0] req_pc = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_redirect;
    logic [31:0] resp_target;
    logic        resp_illegal;
    logic [31:0] mstatus_o, mtvec_o, mepc_o, mcause_o;

    int checks = 0;
    int errors = 0;

    logic        cap_valid;
    logic [31:0] cap_rdata;
    logic        cap_redir;
    logic [31:0] cap_target;
    logic        cap_illegal;

    csr_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_sys(req_sys), .req_csr_addr(req_csr_addr),
        .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_redirect(resp_redirect),
        .resp_target(resp_target), .resp_illegal(resp_illegal),
        .mstatus_o(mstatus_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mcause_o(mcause_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] sys, input logic [11:0] addr,
                         input logic [4:0] idx, input logic [31:0] data, input logic [31:0] pc);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_sys = sys; req_csr_addr = addr;
        req_rs1_idx = idx; req_rs1_data = data; req_pc = pc;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout got %b exp 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        cap_valid = resp_valid; cap_rdata = resp_rdata; cap_redir = resp_redirect;
        cap_target = resp_target; cap_illegal = resp_illegal;
    endtask

    task automatic complete();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_req(input logic [2:0] op, input logic [1:0] sys, input logic [11:0] addr,
                           input logic [4:0] idx, input logic [31:0] data, input logic [31:0] pc);
        issue(op, sys, addr, idx, data, pc);
        complete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        checks++; if ({resp_rdata, resp_target, resp_redirect, resp_illegal} !== 66'd0) begin errors++; $display("FAIL rst_resp_fields got %h/%h/%b/%b exp 0", resp_rdata, resp_target, resp_redirect, resp_illegal); end
        checks++; if (mstatus_o !== 32'h1800) begin errors++; $display("FAIL rst_mstatus got %h exp 1800", mstatus_o); end
        checks++; if (mtvec_o !== 32'h0) begin errors++; $display("FAIL rst_mtvec got %h exp 0", mtvec_o); end
        checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h exp 0", mepc_o); end
        checks++; if (mcause_o !== 32'hb) begin errors++; $display("FAIL rst_mcause got %h exp b", mcause_o); end
    endtask

    task automatic test_read_mstatus();
        issue(3'b010, 2'b00, 12'h300, 5'd0, 32'hFFFF_FFFF, 32'h0);
        checks++; if (cap_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got %b exp 1", cap_valid); end
        checks++; if (cap_rdata !== 32'h1800) begin errors++; $display("FAIL rd_mstatus got %h exp 1800", cap_rdata); end
        checks++; if (cap_redir !== 1'b0 || cap_illegal !== 1'b0) begin errors++; $display("FAIL rd_flags got %b%b exp 00", cap_redir, cap_illegal); end
        checks++; if (mstatus_o !== 32'h1800) begin errors++; $display("FAIL rd_nowrite got %h exp 1800", mstatus_o); end
        complete();
    endtask

    task automatic test_mtvec_ecall();
        run_req(3'b001, 2'b00, 12'h305, 5'd4, 32'h8000_0103, 32'h0);
        checks++; if (cap_rdata !== 32'h0) begin errors++; $display("FAIL mtvec_old got %h exp 0", cap_rdata); end
        checks++; if (mtvec_o !== 32'h8000_0103) begin errors++; $display("FAIL mtvec_wr got %h exp 80000103", mtvec_o); end
        run_req(3'b010, 2'b00, 12'h305, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h8000_0103) begin errors++; $display("FAIL mtvec_rd got %h exp 80000103", cap_rdata); end
        run_req(3'b000, 2'b01, 12'h000, 5'd0, 32'h0, 32'h8000_0040);
        checks++; if (cap_redir !== 1'b1 || cap_target !== 32'h8000_0100) begin errors++; $display("FAIL ecall_target got %b/%h exp 1/80000100", cap_redir, cap_target); end
        checks++; if (cap_rdata !== 32'h0 || cap_illegal !== 1'b0) begin errors++; $display("FAIL ecall_rdata got %h/%b exp 0/0", cap_rdata, cap_illegal); end
        checks++; if (mepc_o !== 32'h8000_0040) begin errors++; $display("FAIL ecall_mepc got %h exp 80000040", mepc_o); end
        checks++; if (mcause_o !== 32'hb) begin errors++; $display("FAIL ecall_mcause got %h exp b", mcause_o); end
        checks++; if (mstatus_o !== 32'h1800) begin errors++; $display("FAIL ecall_mstatus got %h exp 1800", mstatus_o); end
    endtask

    task automatic test_ecall_mret();
        run_req(3'b001, 2'b00, 12'h300, 5'd2, 32'h8, 32'h0);
        checks++; if (cap_rdata !== 32'h1800 || mstatus_o !== 32'h8) begin errors++; $display("FAIL mie_set got %h/%h exp 1800/8", cap_rdata, mstatus_o); end
        run_req(3'b000, 2'b01, 12'h000, 5'd0, 32'h0, 32'h8000_0080);
        checks++; if (mstatus_o !== 32'h1880) begin errors++; $display("FAIL ecall2_mstatus got %h exp 1880", mstatus_o); end
        checks++; if (mepc_o !== 32'h8000_0080) begin errors++; $display("FAIL ecall2_mepc got %h exp 80000080", mepc_o); end
        run_req(3'b000, 2'b10, 12'h000, 5'd0, 32'h0, 32'h0);
        checks++; if (mstatus_o !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp 1888", mstatus_o); end
        checks++; if (cap_redir !== 1'b1 || cap_target !== 32'h8000_0080) begin errors++; $display("FAIL mret_target got %b/%h exp 1/80000080", cap_redir, cap_target); end
    endtask

    task automatic test_clear_and_imm();
        run_req(3'b011, 2'b00, 12'h300, 5'd5, 32'h8, 32'h0);
        checks++; if (cap_rdata !== 32'h1888) begin errors++; $display("FAIL rc_old got %h exp 1888", cap_rdata); end
        checks++; if (mstatus_o !== 32'h1880) begin errors++; $display("FAIL rc_new got %h exp 1880", mstatus_o); end
        run_req(3'b101, 2'b00, 12'h340, 5'h1F, 32'hDEAD_BEEF, 32'h0);
        run_req(3'b010, 2'b00, 12'h340, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h1F) begin errors++; $display("FAIL rwi_mscratch got %h exp 1f", cap_rdata); end
        run_req(3'b111, 2'b00, 12'h340, 5'h03, 32'hFFFF_FFFF, 32'h0);
        checks++; if (cap_rdata !== 32'h1F) begin errors++; $display("FAIL rci_old got %h exp 1f", cap_rdata); end
        run_req(3'b011, 2'b00, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'h0);
        run_req(3'b110, 2'b00, 12'h340, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h1C) begin errors++; $display("FAIL suppress_mscratch got %h exp 1c", cap_rdata); end
        run_req(3'b001, 2'b00, 12'h341, 5'd7, 32'h0000_1237, 32'h0);
        checks++; if (mepc_o !== 32'h1234) begin errors++; $display("FAIL mepc_align got %h exp 1234", mepc_o); end
    endtask

    task automatic test_hold();
        issue(3'b010, 2'b00, 12'h305, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 3'b001; req_csr_addr = 12'h340;
            req_rs1_idx = 5'd9; req_rs1_data = 32'h0000_DEAD;
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL hold_hs%0d got v%b r%b exp v1 r0", i, resp_valid, req_ready); end
            checks++; if (resp_rdata !== 32'h8000_0103 || resp_redirect !== 1'b0 || resp_illegal !== 1'b0 || resp_target !== 32'h0) begin errors++; $display("FAIL hold_fields%0d got %h/%b/%b/%h exp 80000103/0/0/0", i, resp_rdata, resp_redirect, resp_illegal, resp_target); end
        end
        req_valid = 1'b0;
        complete();
        run_req(3'b010, 2'b00, 12'h340, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h1C) begin errors++; $display("FAIL hold_noaccept got %h exp 1c", cap_rdata); end
    endtask

    task automatic test_illegal();
        run_req(3'b001, 2'b00, 12'hF14, 5'd1, 32'h5, 32'h9000_0000);
        checks++; if (cap_illegal !== 1'b1 || cap_redir !== 1'b1) begin errors++; $display("FAIL ill_hartid_flags got %b%b exp 11", cap_illegal, cap_redir); end
        checks++; if (cap_target !== 32'h8000_0100 || cap_rdata !== 32'h0) begin errors++; $display("FAIL ill_hartid_resp got %h/%h exp 80000100/0", cap_target, cap_rdata); end
        checks++; if (mcause_o !== 32'h2 || mepc_o !== 32'h9000_0000) begin errors++; $display("FAIL ill_hartid_trap got %h/%h exp 2/90000000", mcause_o, mepc_o); end
        checks++; if (mstatus_o !== 32'h1800 || mtvec_o !== 32'h8000_0103) begin errors++; $display("FAIL ill_hartid_state got %h/%h exp 1800/80000103", mstatus_o, mtvec_o); end
        run_req(3'b010, 2'b00, 12'hF14, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h0 || cap_illegal !== 1'b0) begin errors++; $display("FAIL hartid_rd got %h/%b exp 0/0", cap_rdata, cap_illegal); end
        run_req(3'b010, 2'b00, 12'h7C0, 5'd3, 32'hFF, 32'h9000_0010);
        checks++; if (cap_illegal !== 1'b1 || mcause_o !== 32'h2 || mepc_o !== 32'h9000_0010) begin errors++; $display("FAIL ill_7c0 got %b/%h/%h exp 1/2/90000010", cap_illegal, mcause_o, mepc_o); end
        run_req(3'b010, 2'b00, 12'h340, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h1C) begin errors++; $display("FAIL ill_mscratch got %h exp 1c", cap_rdata); end
    endtask

    task automatic test_system_nop();
        run_req(3'b000, 2'b11, 12'h300, 5'd1, 32'hFFFF_FFFF, 32'h1111_0000);
        checks++; if (cap_valid !== 1'b1 || {cap_rdata, cap_target, cap_redir, cap_illegal} !== 66'd0) begin errors++; $display("FAIL sys_nop got %b %h/%h/%b/%b exp 1 0", cap_valid, cap_rdata, cap_target, cap_redir, cap_illegal); end
        checks++; if (mepc_o !== 32'h9000_0010 || mstatus_o !== 32'h1800) begin errors++; $display("FAIL sys_nop_state got %h/%h exp 90000010/1800", mepc_o, mstatus_o); end
    endtask

    task automatic test_counter();
`ifdef CSR_COUNTERS_EN
        run_req(3'b001, 2'b00, 12'hB80, 5'd1, 32'h0, 32'h0);
        run_req(3'b001, 2'b00, 12'hB00, 5'd1, 32'hFFFF_FFFF, 32'h0);
        // Low half wraps one edge after the write commits, then counts on.
        run_req(3'b010, 2'b00, 12'hB80, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h1) begin errors++; $display("FAIL mcycleh got %h exp 1", cap_rdata); end
        run_req(3'b010, 2'b00, 12'hB00, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h2) begin errors++; $display("FAIL mcycle got %h exp 2", cap_rdata); end
`else
        run_req(3'b010, 2'b00, 12'hB00, 5'd0, 32'h0, 32'h9000_0020);
        checks++; if (cap_illegal !== 1'b1 || mepc_o !== 32'h9000_0020) begin errors++; $display("FAIL mcycle_absent got %b/%h exp 1/90000020", cap_illegal, mepc_o); end
`endif
    endtask

    task automatic test_reset_in_resp();
        issue(3'b001, 2'b00, 12'h340, 5'd1, 32'h55, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstresp_hs got v%b r%b exp v0 r1", resp_valid, req_ready); end
        checks++; if (mstatus_o !== 32'h1800 || mtvec_o !== 32'h0 || mepc_o !== 32'h0 || mcause_o !== 32'hb) begin errors++; $display("FAIL rstresp_csrs got %h/%h/%h/%h exp 1800/0/0/b", mstatus_o, mtvec_o, mepc_o, mcause_o); end
        @(negedge clk);
        rst = 1'b0;
        run_req(3'b010, 2'b00, 12'h340, 5'd0, 32'h0, 32'h0);
        checks++; if (cap_rdata !== 32'h0) begin errors++; $display("FAIL rstresp_mscratch got %h exp 0", cap_rdata); end
    endtask

    initial begin
        test_reset();
        test_read_mstatus();
        test_mtvec_ecall();
        test_ecall_mret();
        test_clear_and_imm();
        test_hold();
        test_illegal();
        test_system_nop();
        test_counter();
        test_reset_in_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
